alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Command front-end that sits directly upstream of tiny_alu.
- Accepts ALU commands on a valid/ready interface and buffers them in a FIFO.
- Issues them one at a time to tiny_alu using its start/done handshake.
- Returns each result, tagged with its opcode, on a valid/ready response interface. This replaces hand-driven start/done sequencing.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT, 16, max cycles alu_start may stay high without alu_done before the command is aborted; minimum 4.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- alu_start  out  1  to tiny_alu start.
- alu_op  out  3  to tiny_alu op.
- alu_a  out  8  to tiny_alu A.
- alu_b  out  8  to tiny_alu B.
- alu_done  in  1  from tiny_alu done.
- alu_result  in  16  from tiny_alu result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_op  out  3  opcode of the completed command.
- rsp_result  out  16  ALU result; 0 on error.
- rsp_err  out  1  timeout abort flag, qualified by rsp_valid.
- illegal_op  out  1  one-cycle pulse when an opcode outside {add, and, xor, mul} is accepted.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (async, reset_n low):
  - All outputs 0, FIFO empty, state IDLE, timeout counter 0.
  - cmd_ready rises to 1 in the first cycle after reset_n is released.
  - Reset mid-operation discards FIFO contents and any pending response, and drops alu_start immediately.
- Push: cmd_valid && cmd_ready at a rising edge.
  - Opcodes 000, 101, 110 and 111 are never written to the FIFO; they pulse illegal_op for one cycle in the next cycle.
  - Legal opcodes are written {op, a, b}.
  - cmd_ready depends only on full. There is no push into a full FIFO even if a pop happens in the same cycle.
- Pop: occurs on the IDLE->ISSUE transition. Push and pop in the same cycle leave count unchanged.
- Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RSP, GAP.
  - IDLE:
    - If the FIFO is non-empty: pop the head, register it into alu_op/alu_a/alu_b, set alu_start=1, clear the timer, and go to ISSUE.
    - Issue occurs one cycle after the push into an empty FIFO at the earliest.
  - ISSUE:
    - alu_start stays 1 and alu_op/alu_a/alu_b stay stable.
    - The timer increments each cycle.
    - On alu_done=1: capture alu_result into rsp_result, set rsp_op, rsp_err=0, alu_start=0, rsp_valid=1, and go to RSP.
    - Else, if the timer reaches TIMEOUT-1: set rsp_result=0, rsp_err=1, alu_start=0, rsp_valid=1, and go to RSP.
    - If alu_done and the timeout hit in the same cycle, alu_done wins.
  - RSP:
    - rsp_valid, rsp_op, rsp_result and rsp_err are held stable until rsp_ready=1.
    - On the handshake, rsp_valid drops the next cycle and the FSM goes to GAP.
  - GAP:
    - One cycle with alu_start=0, guaranteeing tiny_alu sees start low between commands; then go to IDLE.
- Minimum spacing between alu_start rising edges: ALU latency + 3 cycles with rsp_ready tied high.
- alu_done seen outside ISSUE is ignored.
- rsp_result is passed through unmodified at 16 bits; no arithmetic is performed by this block.
- Only one command is in flight at a time; responses are returned in command order.

Test Plan:
- Reset, then push add A=8'h05 B=8'h03 with rsp_ready=1:
  - alu_start high the cycle after the push, with alu_op=001.
  - After alu_done: rsp_valid=1, rsp_op=001, rsp_result=16'h0008, rsp_err=0.
- Push mul FF*FF, then and F0&3C, then xor AA^55 back-to-back:
  - Responses arrive in order: 16'hFE01, 16'h0030, 16'h00FF.
  - alu_start is low for at least 1 cycle between commands.
- Hold rsp_ready=0, push DEPTH+1 commands:
  - cmd_ready drops after 4 accepted pushes while one command is in flight, and count=4.
  - rsp_valid and rsp_result stay stable; after releasing rsp_ready, all 5 responses drain in order.
- Push op 000, then op 111:
  - Two illegal_op pulses, count stays 0, alu_start is never raised.
- Bench model withholds alu_done:
  - alu_start drops after 16 cycles.
  - Response has rsp_err=1, rsp_result=0; the next queued command then issues normally.
- Assert reset_n low mid-ISSUE with 2 entries queued:
  - alu_start, rsp_valid and count all go to 0 immediately.
  - After release, no stale command is issued.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a small FIFO, issues them one at a
// time to tiny_alu over its start/done handshake and returns each result,
// tagged with its opcode, on a valid/ready response channel.
module alu_cmd_issuer #(
    parameter int DEPTH   = 4,   // command FIFO entries, power of 2, >= 2
    parameter int TIMEOUT = 16   // max cycles alu_start may wait for alu_done, >= 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    // command intake
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [7:0]              cmd_a,
    input  logic [7:0]              cmd_b,
    // tiny_alu side
    output logic                    alu_start,
    output logic [2:0]              alu_op,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    input  logic                    alu_done,
    input  logic [15:0]             alu_result,
    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2:0]              rsp_op,
    output logic [15:0]             rsp_result,
    output logic                    rsp_err,
    // status
    output logic                    illegal_op,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RSP,
        S_GAP
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    // FIFO storage and bookkeeping
    cmd_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          illegal_op_q, illegal_op_d;

    logic          push;
    logic          op_legal;
    logic          wr_en;
    logic          pop;

    // issue / response state
    state_e        state_q, state_d;
    logic          alu_start_q, alu_start_d;
    cmd_t          alu_cmd_q, alu_cmd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [2:0]    rsp_op_q, rsp_op_d;
    logic [15:0]   rsp_result_q, rsp_result_d;
    logic          rsp_err_q, rsp_err_d;

    // Decode an accepted command: legal ones go into the FIFO, the rest only flag
    always_comb begin
        op_legal     = (cmd_op == OP_ADD) || (cmd_op == OP_AND) ||
                       (cmd_op == OP_XOR) || (cmd_op == OP_MUL);
        push         = cmd_valid && cmd_ready_q;
        wr_en        = push && op_legal;
        illegal_op_d = push && !op_legal;
    end

    // Pointer and occupancy update; ready is registered from the next occupancy
    // so it depends on fullness only and comes up one cycle after reset
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d     = count_q + CW'(wr_en) - CW'(pop);
        cmd_ready_d = (count_d != FULL_COUNT);
    end

    // FIFO payload write
    // NOTE: the storage array has no reset; emptiness is tracked by count_q and
    // the pointers, so stale entries are never read and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    // Issue FSM: next state, ALU drive and response capture
    // NOTE: every *_d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        alu_start_d  = alu_start_q;
        alu_cmd_d    = alu_cmd_q;
        timer_d      = timer_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_op_d     = rsp_op_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    alu_cmd_d   = fifo_mem[rd_ptr_q];
                    alu_start_d = 1'b1;
                    timer_d     = '0;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                timer_d = timer_q + TW'(1);
                if (alu_done) begin
                    // a completion in the same cycle as the timeout still wins
                    rsp_result_d = alu_result;
                    rsp_op_d     = alu_cmd_q.op;
                    rsp_err_d    = 1'b0;
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RSP;
                end else if (timer_q == TIMER_LAST) begin
                    rsp_result_d = '0;
                    rsp_op_d     = alu_cmd_q.op;
                    rsp_err_d    = 1'b1;
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RSP;
                end
            end

            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_GAP;
                end
            end

            S_GAP: begin
                // guarantees tiny_alu sees start low between commands
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and control registers, all cleared by the asynchronous reset
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cmd_ready_q  <= 1'b0;
            illegal_op_q <= 1'b0;
            state_q      <= S_IDLE;
            alu_start_q  <= 1'b0;
            alu_cmd_q    <= '0;
            timer_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cmd_ready_q  <= cmd_ready_d;
            illegal_op_q <= illegal_op_d;
            state_q      <= state_d;
            alu_start_q  <= alu_start_d;
            alu_cmd_q    <= alu_cmd_d;
            timer_q      <= timer_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign illegal_op = illegal_op_q;
    assign count      = count_q;
    assign alu_start  = alu_start_q;
    assign alu_op     = alu_cmd_q.op;
    assign alu_a      = alu_cmd_q.a;
    assign alu_b      = alu_cmd_q.b;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus a random
// phase, scored against a queue-based model and a behavioural tiny_alu.
module tb_alu_cmd_issuer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [7:0]    cmd_a;
    logic [7:0]    cmd_b;
    logic          alu_start;
    logic [2:0]    alu_op;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_done;
    logic [15:0]   alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_op;
    logic [15:0]   rsp_result;
    logic          rsp_err;
    logic          illegal_op;
    logic [CW-1:0] count;

    alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_op     (rsp_op),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .illegal_op (illegal_op),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        bit         wh;   // bench ALU withholds done for this command
    } cmd_s;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] res;
        bit          err;
    } rsp_s;

    cmd_s cmdq[$];   // accepted, not yet issued
    rsp_s rspq[$];   // issued, response not yet consumed
    cmd_s cur_cmd;

    int checks   = 0;
    int failures = 0;

    // model / monitor state
    int  mcount      = 0;
    bit  settled     = 0;
    bit  illegal_exp = 0;
    bit  prev_start  = 0;
    bit  had_fall    = 0;
    bit  cur_wh      = 0;
    int  lat         = 1;
    int  high_cnt    = 0;
    int  low_cnt     = 0;
    int  start_rises = 0;
    int  illegal_cnt = 0;
    bit  exp_ready;

    // stimulus controls
    bit  drv_wh      = 0;
    bit  spurious_en = 0;
    int  rsp_mode    = 0;   // 0: ready high, 1: random, 2: held low

    logic [2:0] r_op;
    logic [2:0] ill_ops [4];
    int         base_rises;
    int         base_ill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return 16'(a & b);
            3'd3:    return 16'(a ^ b);
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0;
        endcase
    endfunction

    // Response consumer
    always @(posedge clk) begin
        #2;
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor, scoreboard and behavioural tiny_alu, all evaluated mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            cmdq.delete();
            rspq.delete();
            mcount      = 0;
            settled     = 0;
            illegal_exp = 0;
            prev_start  = 0;
            had_fall    = 0;
            cur_wh      = 0;
            high_cnt    = 0;
            low_cnt     = 0;
            alu_done    = 1'b0;
        end else begin
            // issue of the next queued command
            if (alu_start && !prev_start) begin
                start_rises++;
                if (cmdq.size() == 0) begin
                    check("issue_without_cmd", 32'(1), 32'(0));
                end else begin
                    cur_cmd = cmdq.pop_front();
                    check("issue_cmd", 32'({alu_op, alu_a, alu_b}),
                          32'({cur_cmd.op, cur_cmd.a, cur_cmd.b}));
                    if (had_fall) check("start_gap", 32'(low_cnt >= 3), 32'(1));
                    mcount  -= 1;
                    cur_wh   = cur_cmd.wh;
                    lat      = $urandom_range(1, 4);
                    high_cnt = 0;
                    rspq.push_back('{op: cur_cmd.op,
                                     res: cur_cmd.wh ? 16'h0 : alu_ref(cur_cmd.op, cur_cmd.a, cur_cmd.b),
                                     err: cur_cmd.wh});
                end
            end
            if (alu_start) begin
                high_cnt++;
            end else if (prev_start) begin
                check("start_width", 32'(high_cnt), cur_wh ? 32'(TIMEOUT) : 32'(lat));
                had_fall = 1;
                low_cnt  = 1;
            end else begin
                low_cnt++;
            end
            prev_start = alu_start;

            // tiny_alu: done after 'lat' cycles of start, unless withheld
            if (alu_start && !cur_wh && high_cnt == lat) begin
                alu_done   = 1'b1;
                alu_result = alu_ref(alu_op, alu_a, alu_b);
            end else begin
                alu_done   = spurious_en && !alu_start && ($urandom_range(0, 7) == 0);
                alu_result = 16'($urandom);
            end

            // response channel, held stable until consumed
            if (rsp_valid) begin
                if (rspq.size() == 0) begin
                    check("rsp_unexpected", 32'(1), 32'(0));
                end else begin
                    check("rsp", 32'({rsp_op, rsp_result, rsp_err}),
                          32'({rspq[0].op, rspq[0].res, rspq[0].err}));
                    if (rsp_ready) void'(rspq.pop_front());
                end
            end

            // occupancy, ready and illegal pulse
            exp_ready = settled && (mcount != DEPTH);
            check("count", 32'(count), 32'(mcount));
            check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            check("illegal_op", 32'(illegal_op), 32'(illegal_exp));
            if (illegal_op) illegal_cnt++;
            settled = 1;

            // predict what the coming edge accepts
            illegal_exp = 0;
            if (cmd_valid && exp_ready) begin
                if (cmd_op >= 3'd1 && cmd_op <= 3'd4) begin
                    cmdq.push_back('{op: cmd_op, a: cmd_a, b: cmd_b, wh: drv_wh});
                    mcount += 1;
                end else begin
                    illegal_exp = 1;
                end
            end
        end
    end

    // Offer one command and hold it until accepted (called at posedge+2)
    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit wh = 0);
        bit acc;
        acc       = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        drv_wh    = wh;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #2;
        end
        cmd_valid = 1'b0;
        drv_wh    = 0;
        if (!acc) check("push_accept_timeout", 32'(0), 32'(1));
    endtask

    // Wait until every accepted command has been answered and consumed
    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 2000 && !idle; i++) begin
            @(negedge clk);
            idle = (cmdq.size() == 0) && (rspq.size() == 0) && !alu_start && !rsp_valid && (count == 0);
        end
        check("drain", 32'(idle), 32'(1));
        @(posedge clk);
        #2;
    endtask

    // Wait for the next response and compare it with explicit values
    task automatic wait_rsp(input string tag, input logic [2:0] op, input logic [15:0] res, input bit err);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check({tag, "_seen"}, 32'(seen), 32'(1));
        check(tag, 32'({rsp_op, rsp_result, rsp_err}), 32'({op, res, err}));
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ill_ops    = '{3'd0, 3'd5, 3'd6, 3'd7};
        reset_n    = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b1;
        alu_done   = 1'b0;
        alu_result = '0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_alu", 32'({alu_start, alu_op, alu_a, alu_b}), 32'(0));
        check("rst_rsp", 32'({rsp_valid, rsp_op, rsp_result, rsp_err}), 32'(0));
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_illegal", 32'(illegal_op), 32'(0));
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cycles(2);

        // single add; start must follow the push by one cycle
        push(3'd1, 8'h05, 8'h03);
        @(negedge clk);
        check("add_no_early_start", 32'(alu_start), 32'(0));
        @(negedge clk);
        check("add_issue", 32'({alu_start, alu_op, alu_a, alu_b}), 32'({1'b1, 3'd1, 8'h05, 8'h03}));
        @(posedge clk);
        #2;
        wait_rsp("add_rsp", 3'd1, 16'h0008, 1'b0);
        wait_idle();

        // back-to-back mul, and, xor
        push(3'd4, 8'hFF, 8'hFF);
        push(3'd2, 8'hF0, 8'h3C);
        push(3'd3, 8'hAA, 8'h55);
        wait_rsp("mul_rsp", 3'd4, 16'hFE01, 1'b0);
        wait_rsp("and_rsp", 3'd2, 16'h0030, 1'b0);
        wait_rsp("xor_rsp", 3'd3, 16'h00FF, 1'b0);
        wait_idle();

        // fill with the consumer stalled
        rsp_mode = 2;
        cycles(1);
        for (int i = 0; i < DEPTH + 1; i++) push(3'd1, 8'(i * 7), 8'(i + 1));
        @(negedge clk);
        check("fill_count", 32'(count), 32'(DEPTH));
        check("fill_ready", 32'(cmd_ready), 32'(0));
        check("fill_rsp_held", 32'(rsp_valid), 32'(1));
        @(posedge clk);
        #2;
        cycles(6);
        rsp_mode = 0;
        wait_idle();

        // illegal opcodes are flagged and dropped
        base_rises = start_rises;
        base_ill   = illegal_cnt;
        push(3'd0, 8'h11, 8'h22);
        push(3'd7, 8'h33, 8'h44);
        cycles(5);
        check("illegal_pulses", 32'(illegal_cnt - base_ill), 32'(2));
        check("illegal_no_issue", 32'(start_rises), 32'(base_rises));
        check("illegal_count", 32'(count), 32'(0));

        // timeout on a withheld done, next command then runs normally
        push(3'd1, 8'h01, 8'h02, 1);
        push(3'd3, 8'h12, 8'h34);
        wait_rsp("timeout_rsp", 3'd1, 16'h0000, 1'b1);
        wait_rsp("after_timeout_rsp", 3'd3, 16'h0026, 1'b0);
        wait_idle();

        // reset during ISSUE with two entries queued
        push(3'd4, 8'h10, 8'h10, 1);
        push(3'd1, 8'h20, 8'h20);
        push(3'd2, 8'h30, 8'h30);
        @(negedge clk);
        check("pre_reset_state", 32'({alu_start, count}), 32'({1'b1, CW'(2)}));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(alu_start), 32'(0));
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_count", 32'(count), 32'(0));
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        base_rises = start_rises;
        cycles(10);
        check("no_stale_issue", 32'(start_rises), 32'(base_rises));
        push(3'd3, 8'h0F, 8'hF0);
        wait_rsp("post_reset_rsp", 3'd3, 16'h00FF, 1'b0);
        wait_idle();

        // random traffic with a flaky consumer and spurious done pulses
        rsp_mode    = 1;
        spurious_en = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 8) r_op = 3'($urandom_range(1, 4));
            else                          r_op = ill_ops[$urandom_range(0, 3)];
            push(r_op, 8'($urandom), 8'($urandom), $urandom_range(0, 9) == 0);
            cycles($urandom_range(0, 3));
        end
        wait_idle();
        spurious_en = 0;
        rsp_mode    = 0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
